// File: rtl/decrypted_word_buffer.sv
// -----------------------------------------------------------------------------
// decrypted_word_buffer
//
// Purpose
//   Circular FIFO between a decrypter (push side) and a readout engine
//   (pop side).  Words arrive as one-cycle valid_in strobes and are popped
//   with rd_en_in.  The popped word appears on the registered rd_data_out
//   one cycle after the request, qualified by rd_valid_out.  A write that
//   finds the buffer full and is not accompanied by a read sets the sticky
//   overflow_out flag.
//
// Configuration macro
//   DECRYPT_BUF_DROP_OLDEST_EN
//     defined   : on overflow the incoming word replaces the oldest stored
//                 word.  Both pointers advance and the count stays at depth_g.
//     undefined : on overflow the incoming word is discarded.  Storage and
//                 pointers are left untouched.  This is the default build.
//
// Parameters
//   data_width_g  width of a decrypted word (default 32)
//   depth_g       buffer depth in words; must be a power of 2 and >= 2
//
// Ports
//   clk           in   single clock; all logic runs on the rising edge
//   rst_n         in   synchronous active-low reset
//   valid_in      in   one-cycle strobe: decrypted_in holds a new word
//   decrypted_in  in   decrypted word from the decrypter
//   rd_en_in      in   pop request from the readout side
//   rd_data_out   out  popped word (registered; holds when rd_valid_out=0)
//   rd_valid_out  out  one-cycle strobe: rd_data_out holds a popped word
//   empty_out     out  occupancy count is 0
//   full_out      out  occupancy count is depth_g
//   count_out     out  number of words stored
//   overflow_out  out  sticky flag: a word was lost to a full buffer
//   clr_ovf_in    in   clears overflow_out (a same-cycle overflow wins)
// -----------------------------------------------------------------------------
module decrypted_word_buffer #(
  parameter int data_width_g = 32,
  parameter int depth_g      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [data_width_g-1:0]        decrypted_in,
  input  logic                           rd_en_in,
  output logic [data_width_g-1:0]        rd_data_out,
  output logic                           rd_valid_out,
  output logic                           empty_out,
  output logic                           full_out,
  output logic [$clog2(depth_g+1)-1:0]   count_out,
  output logic                           overflow_out,
  input  logic                           clr_ovf_in
);

  localparam int AW = (depth_g > 1) ? $clog2(depth_g) : 1;
  localparam int CW = $clog2(depth_g + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth_g);

  // Storage array; deliberately not reset.
  logic [data_width_g-1:0] r_mem [depth_g];

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [data_width_g-1:0] r_rd_data;
  logic                    r_rd_valid;
  logic                    r_ovf;

  logic w_empty;
  logic w_full;
  logic w_rd;        // accepted pop
  logic w_wr;        // accepted push into a free slot (or a slot freed this cycle)
  logic w_ovf_evt;   // push that finds the buffer full with no pop alongside
  logic w_mem_we;
  logic w_wr_adv;
  logic w_rd_adv;

  // depth_g is a power of 2, so pointer wrap from depth_g-1 to 0 is the
  // natural modulo-2^AW rollover of the increment.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A pop on an empty buffer is ignored, even if a push arrives in the same
  // cycle: the pushed word is stored, never forwarded straight through.
  assign w_rd      = rd_en_in && !w_empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_wr      = valid_in && (!w_full || w_rd);
  assign w_ovf_evt = valid_in && w_full && !w_rd;

`ifdef DECRYPT_BUF_DROP_OLDEST_EN
  // When full, wr_ptr == rd_ptr, so writing at wr_ptr overwrites the oldest
  // word; advancing both pointers keeps the count at depth_g.
  assign w_mem_we = w_wr || w_ovf_evt;
  assign w_wr_adv = w_wr || w_ovf_evt;
  assign w_rd_adv = w_rd || w_ovf_evt;
`else
  assign w_mem_we = w_wr;
  assign w_wr_adv = w_wr;
  assign w_rd_adv = w_rd;
`endif

  // Storage write
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      r_mem[r_wr_ptr] <= decrypted_in;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_adv) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd_adv) r_rd_ptr <= ptr_next(r_rd_ptr);
      // An overflow (either policy) leaves the count unchanged.
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data register: one-cycle latency from an accepted pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_in) begin
      r_ovf <= 1'b0;
    end
  end

  assign rd_data_out  = r_rd_data;
  assign rd_valid_out = r_rd_valid;
  assign empty_out    = w_empty;
  assign full_out     = w_full;
  assign count_out    = r_count;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_decrypted_word_buffer.sv
// -----------------------------------------------------------------------------
// tb_decrypted_word_buffer
//
// Self-checking bench for decrypted_word_buffer (depth 8, 32-bit words).
// A queue-based reference model tracks the stored words, the registered read
// outputs and the sticky overflow flag.  Honours DECRYPT_BUF_DROP_OLDEST_EN
// the same way the design does.
// -----------------------------------------------------------------------------
module tb_decrypted_word_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = CW + 4 + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] decrypted_in;
  logic          rd_en_in;
  logic [DW-1:0] rd_data_out;
  logic          rd_valid_out;
  logic          empty_out;
  logic          full_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  logic          clr_ovf_in;

  always #5 clk = ~clk;

  decrypted_word_buffer #(
    .data_width_g (DW),
    .depth_g      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .decrypted_in (decrypted_in),
    .rd_en_in     (rd_en_in),
    .rd_data_out  (rd_data_out),
    .rd_valid_out (rd_valid_out),
    .empty_out    (empty_out),
    .full_out     (full_out),
    .count_out    (count_out),
    .overflow_out (overflow_out),
    .clr_ovf_in   (clr_ovf_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_rd_valid = 1'b0;
  logic [DW-1:0] m_rd_data  = '0;
  logic          m_ovf      = 1'b0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {count_out, empty_out, full_out, overflow_out, rd_valid_out, rd_data_out};

  function automatic logic [VW-1:0] exp_vec();
    int n;
    n = q.size();
    return {CW'(n), (n == 0), (n == DEPTH), m_ovf, m_rd_valid, m_rd_data};
  endfunction

  // Drive one clock of inputs, advance the model at the edge, settle 1 time unit.
  task automatic tick(input logic rn, input logic v, input logic [DW-1:0] d,
                      input logic r, input logic c);
    logic ovf_now;
    rst_n = rn; valid_in = v; decrypted_in = d; rd_en_in = r; clr_ovf_in = c;
    @(posedge clk);
    ovf_now = 1'b0;
    if (!rn) begin
      q.delete();
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
      m_ovf      = 1'b0;
    end else begin
      if (r && q.size() > 0) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (v) begin
        if (q.size() < DEPTH) begin
          q.push_back(d);
        end else begin
          ovf_now = 1'b1;
`ifdef DECRYPT_BUF_DROP_OLDEST_EN
          void'(q.pop_front());
          q.push_back(d);
`endif
        end
      end
      if (ovf_now) m_ovf = 1'b1;
      else if (c)  m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    end
    n_checks++;
    if (count_out !== '0 || empty_out !== 1'b1 || full_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b, want 0/1/0", count_out, empty_out, full_out);
    end
    n_checks++;
    if (overflow_out !== 1'b0 || rd_valid_out !== 1'b0 || rd_data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ovf=%b rd_valid=%b rd_data=%h, want 0/0/0", overflow_out, rd_valid_out, rd_data_out);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 32'hA5A5_0001 + DW'(i), 1'b0, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      w = 32'hA5A5_0001 + DW'(i);
      tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid_out !== 1'b1 || rd_data_out !== w) begin
        n_fail++;
        $display("FAIL basic_pop%0d: rd_valid=%b rd_data=%h want 1/%h", i, rd_valid_out, rd_data_out, w);
      end
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (empty_out !== 1'b1 || rd_valid_out !== 1'b0 || rd_data_out !== 32'hA5A5_0003) begin
      n_fail++;
      $display("FAIL basic_end: empty=%b rd_valid=%b rd_data=%h want 1/0/a5a50003", empty_out, rd_valid_out, rd_data_out);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w;
    for (int i = 1; i <= 9; i++) tick(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
    n_checks++;
    if (full_out !== 1'b1 || overflow_out !== 1'b1 || count_out !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_full: full=%b ovf=%b count=%0d want 1/1/8", full_out, overflow_out, count_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
`ifdef DECRYPT_BUF_DROP_OLDEST_EN
      w = DW'(i + 2);
`else
      w = DW'(i + 1);
`endif
      tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid_out !== 1'b1 || rd_data_out !== w) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: rd_valid=%b rd_data=%h want 1/%h", i, rd_valid_out, rd_data_out, w);
      end
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow_out !== 1'b0 || empty_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b empty=%b want 0/1", overflow_out, empty_out);
    end
  endtask

  task automatic test_empty_rw();
    tick(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_out !== 1'b0 || count_out !== CW'(1)) begin
      n_fail++;
      $display("FAIL empty_rw: rd_valid=%b count=%0d want 0/1", rd_valid_out, count_out);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_out !== 1'b1 || rd_data_out !== 32'hDEAD_BEEF || count_out !== '0) begin
      n_fail++;
      $display("FAIL empty_rw_pop: rd_valid=%b rd_data=%h count=%0d want 1/deadbeef/0", rd_valid_out, rd_data_out, count_out);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, 32'h1000 + DW'(i), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'hCAFE_0000, 1'b1, 1'b0);
    n_checks++;
    if (count_out !== CW'(DEPTH) || overflow_out !== 1'b0 || rd_valid_out !== 1'b1 || rd_data_out !== 32'h1000) begin
      n_fail++;
      $display("FAIL full_rw: count=%0d ovf=%b rd_valid=%b rd_data=%h want 8/0/1/00001000",
               count_out, overflow_out, rd_valid_out, rd_data_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_rw_drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, $urandom, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    // Reset with a read and a write pending in the same cycle
    tick(1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    n_checks++;
    if (count_out !== '0 || empty_out !== 1'b1 || rd_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: count=%0d empty=%b rd_valid=%b want 0/1/0", count_out, empty_out, rd_valid_out);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_out !== 1'b0 || count_out !== '0 || rd_data_out !== '0) begin
      n_fail++;
      $display("FAIL post_reset_read: rd_valid=%b count=%0d rd_data=%h want 0/0/0", rd_valid_out, count_out, rd_data_out);
    end
  endtask

  task automatic test_clear_ovf();
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    n_checks++;
    if (overflow_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b want 1", overflow_out);
    end
    // New overflow and clear in the same cycle: overflow wins
    tick(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    n_checks++;
    if (overflow_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_priority: ovf=%b want 1", overflow_out);
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow_out !== 1'b0 || count_out !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%b count=%0d want 0/8", overflow_out, count_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic rn, v, r, c;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5);
      c  = ($urandom_range(0, 9) == 0);
      tick(rn, v, $urandom, r, c);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; decrypted_in = '0; rd_en_in = 1'b0; clr_ovf_in = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_empty_rw();
    test_full_rw();
    test_wrap_reset();
    test_clear_ovf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
